// File: rtl/pc_unit_if.sv
// Program-counter unit bus: sequencing commands from decode/branch logic and
// the registered fetch address plus RAS status back.
// Optional trap/return signals exist only when PC_TRAP_EN is defined.
interface pc_unit_if #(
  parameter int PC_W = 16
);
  logic                   pc_en;
  logic                   br_take;
  logic signed [PC_W-1:0] br_off;
  logic                   jmp;
  logic                   call;
  logic                   ret;
  logic        [PC_W-1:0] jmp_addr;
  logic        [PC_W-1:0] pc;
  logic                   ras_empty;
  logic                   ras_full;
  logic                   ras_ovf;
  logic                   ras_unf;
`ifdef PC_TRAP_EN
  logic                   trap;
  logic                   eret;
  logic        [PC_W-1:0] epc;
  logic                   in_trap;
`endif

  // Decode side: issues commands, observes the fetch address.
  modport master (
    output pc_en, br_take, br_off, jmp, call, ret, jmp_addr,
`ifdef PC_TRAP_EN
    output trap, eret,
    input  epc, in_trap,
`endif
    input  pc, ras_empty, ras_full, ras_ovf, ras_unf
  );

  // PC unit side.
  modport slave (
    input  pc_en, br_take, br_off, jmp, call, ret, jmp_addr,
`ifdef PC_TRAP_EN
    input  trap, eret,
    output epc, in_trap,
`endif
    output pc, ras_empty, ras_full, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: registered fetch address with fixed-priority next-PC
// selection (trap > eret > ret > call > jmp > branch > increment) and a
// circular return-address stack with saturating occupancy count.
// Optional feature macro: PC_TRAP_EN adds trap entry / exception return.
module pc_unit #(
  parameter int              PC_W      = 16,
  parameter int              INC       = 1,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'('hFFF0)
) (
  input logic        clk,
  input logic        reset_n,
  pc_unit_if.slave   bus
);

  localparam int              PTR_W   = $clog2(RAS_DEPTH);
  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [PC_W-1:0] INC_V   = PC_W'(INC);
  localparam logic [CNT_W-1:0] DEPTH_V = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  // Relative branch target; the offset is two's complement and the sum wraps.
  function automatic logic [PC_W-1:0] pc_rel_add(
    input logic        [PC_W-1:0] base,
    input logic signed [PC_W-1:0] off
  );
    return base + $unsigned(off);
  endfunction

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  ras_top;
`ifdef PC_TRAP_EN
  logic [PC_W-1:0]  epc_q, epc_d;
  logic             in_trap_q, in_trap_d;
`endif

  // sp points at the next free slot; the top entry sits just below it.
  assign pc_inc  = pc_q + INC_V;
  assign ras_top = ras_mem[sp_q - PTR_ONE];

  // Next-state selection in priority order; increment is the fallthrough.
  always_comb begin
    pc_d  = pc_inc;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    push  = 1'b0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
`ifdef PC_TRAP_EN
    epc_d     = epc_q;
    in_trap_d = in_trap_q;
    if (bus.trap && !in_trap_q) begin
      epc_d     = pc_q;
      pc_d      = TRAP_VEC;
      in_trap_d = 1'b1;
    end else if (bus.eret && in_trap_q) begin
      pc_d      = epc_q;
      in_trap_d = 1'b0;
    end else
`endif
    if (bus.ret) begin
      if (cnt_q == '0) begin
        unf_d = 1'b1;
      end else begin
        pc_d  = ras_top;
        sp_d  = sp_q - PTR_ONE;
        cnt_d = cnt_q - CNT_ONE;
      end
    end else if (bus.call) begin
      push = 1'b1;
      pc_d = bus.jmp_addr;
      sp_d = sp_q + PTR_ONE;
      if (cnt_q == DEPTH_V) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (bus.jmp) begin
      pc_d = bus.jmp_addr;
    end else if (bus.br_take) begin
      pc_d = pc_rel_add(pc_q, bus.br_off);
    end
  end

  // Control/PC state: reset wins, stall holds state and squashes the pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q      <= RESET_VEC;
      sp_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
`ifdef PC_TRAP_EN
      epc_q     <= '0;
      in_trap_q <= 1'b0;
`endif
    end else if (bus.pc_en) begin
      pc_q      <= pc_d;
      sp_q      <= sp_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
`ifdef PC_TRAP_EN
      epc_q     <= epc_d;
      in_trap_q <= in_trap_d;
`endif
    end else begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end
  end

  // Stack storage is data only; a full stack overwrites its oldest slot.
  always_ff @(posedge clk) begin
    if (reset_n && bus.pc_en && push) begin
      ras_mem[sp_q] <= pc_inc;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.ras_empty = (cnt_q == '0);
  assign bus.ras_full  = (cnt_q == DEPTH_V);
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_unf   = unf_q;
`ifdef PC_TRAP_EN
  assign bus.epc       = epc_q;
  assign bus.in_trap   = in_trap_q;
`endif

endmodule
